log2_core: RTL and testbench
============================

LOG2_CORE -- requirements
Module: log2_core

Interface
REQ-001 SHALL have port hclk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port data_a, input, 32 bits: unsigned operand, sampled only when accepted.
REQ-004 SHALL have port data_a_valid, input, 1 bit: one-cycle request strobe from the AHB log register block.
REQ-005 SHALL have port data_log, output, 32 bits: result, Q16.16 two's-complement, held between results.
REQ-006 SHALL have port data_log_valide, output, 1 bit: one-cycle result strobe.
REQ-007 SHALL have port busy, output, 1 bit: high while a computation is in flight.
REQ-008 SHALL have port overrun, output, 1 bit: one-cycle pulse when a request is dropped.

Function
REQ-009 SHALL implement FSM states IDLE, NORM, FRAC, SCALE, DONE.
REQ-010 SHALL accept a request when data_a_valid=1 in IDLE or DONE: capture data_a, go to NORM.
REQ-011 SHALL set busy=1 in NORM, FRAC and SCALE, and 0 in IDLE and DONE.
REQ-012 SHALL ignore data_a_valid in NORM/FRAC/SCALE and pulse overrun the next cycle; the in-flight operation is unaffected.
REQ-013 NORM (1 cycle): e = 31 - leading-zero count of x; mantissa m = x << lzc, Q1.31 in [1,2).
REQ-014 FRAC (exactly 16 cycles, 4-bit counter): s = m*m as a 64-bit Q2.62 value; if s[63]=1, fraction bit = 1 and m = s[63:32]; else bit = 0 and m = s[62:31]; bits fill MSB-first.
REQ-015 SHALL form log2 result as {11'b0, e[4:0], frac[15:0]}.
REQ-016 SHALL treat x=0 as a flag: same latency, result 0x8000_0000, no scaling applied.
REQ-017 SCALE state SHALL be entered only when LOG_LN_SCALE_EN is defined; otherwise FRAC goes directly to DONE.
REQ-018 In DONE, data_log SHALL be registered and data_log_valide=1 for exactly one cycle; DONE goes to IDLE unless a new request is accepted that cycle.
REQ-019 Latency SHALL be fixed: data_log_valide high 18 cycles after the accepting edge (19 with LOG_LN_SCALE_EN), independent of operand value.
REQ-020 Back-to-back: a request accepted in DONE SHALL produce its own valid exactly L cycles later, with no lost strobe.
REQ-021 data_log SHALL change only on the edge that raises data_log_valide.

Reset
REQ-022 On rst=1: state IDLE, data_log=0x0000_0000, data_log_valide=0, busy=0, overrun=0, counter=0.
REQ-023 Reset mid-operation SHALL abort the computation with no valid pulse; the first request after deassertion SHALL behave normally.

Configuration
REQ-024 Macro LOG_LN_SCALE_EN, defined: SCALE state computes data_log = (log2 × 0xB172) >> 16, truncated (natural log, Q16.16); latency 19.
REQ-025 Macro LOG_LN_SCALE_EN, undefined: no multiplier is instantiated, output is log2, latency 18.

Verification
REQ-026 data_a=1, then 2, then 0x8000_0000 (macro off) -> data_log = 0x0000_0000, 0x0001_0000, 0x001F_0000, each valid at +18 cycles.
REQ-027 data_a=3 (macro off) -> 0x0001_95C0 ±1 LSB; data_a=0 -> 0x8000_0000 at +18.
REQ-028 Macro on: data_a=2 -> 0x0000_B172; data_a=0 -> 0x8000_0000; valid at +19.
REQ-029 Strobe at cycle 0 and again at cycle 5 -> overrun pulse at cycle 6; one result only, for the first operand.
REQ-030 New strobe in the data_log_valide cycle -> second result exactly L cycles later; rst pulse during FRAC -> no valid, outputs at reset values.

Source files
------------

// File: rtl/log2_core.sv
// Sequential log2 of a 32-bit unsigned operand, Q16.16 result, fixed latency.
// Optional macro LOG_LN_SCALE_EN adds a SCALE state that converts the result to natural log.
module log2_core (
    input  logic        hclk,
    input  logic        rst,
    input  logic [31:0] data_a,
    input  logic        data_a_valid,
    output logic [31:0] data_log,
    output logic        data_log_valide,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {IDLE, NORM, FRAC, SCALE, DONE} state_t;

    state_t      state_reg;
    logic [31:0] x_reg;
    logic [31:0] m_reg;
    logic [4:0]  e_reg;
    logic [15:0] frac_reg;
    logic [3:0]  cnt_reg;
    logic        zero_reg;

    logic [4:0]  lzc;
    logic        lz_found;
    logic [31:0] norm_m;
    logic [63:0] sq;
    logic [31:0] log2_word;
    logic [31:0] done_word;
    logic        in_flight;

    // Leading-zero count; an all-zero operand is handled by zero_reg instead.
    always_comb begin
        lzc      = 5'd0;
        lz_found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!lz_found && x_reg[i]) begin
                lzc      = 5'(31 - i);
                lz_found = 1'b1;
            end
        end
    end

    assign norm_m    = x_reg << lzc;
    assign sq        = m_reg * m_reg;
    assign log2_word = zero_reg ? 32'h8000_0000 : {11'b0, e_reg, frac_reg};
    assign in_flight = (state_reg == NORM) || (state_reg == FRAC) || (state_reg == SCALE);

`ifdef LOG_LN_SCALE_EN
    // 0xB172 is ln(2) in Q0.16.
    logic [31:0] result_reg;
    logic [47:0] scale_prod;
    assign scale_prod = {16'b0, log2_word} * 48'h0000_0000_B172;
    assign done_word  = result_reg;
`else
    assign done_word  = log2_word;
`endif

    always_ff @(posedge hclk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            x_reg           <= 32'd0;
            m_reg           <= 32'd0;
            e_reg           <= 5'd0;
            frac_reg        <= 16'd0;
            cnt_reg         <= 4'd0;
            zero_reg        <= 1'b0;
            data_log        <= 32'd0;
            data_log_valide <= 1'b0;
            busy            <= 1'b0;
            overrun         <= 1'b0;
`ifdef LOG_LN_SCALE_EN
            result_reg      <= 32'd0;
`endif
        end else begin
            data_log_valide <= 1'b0;
            overrun         <= data_a_valid && in_flight;
            case (state_reg)
                IDLE: begin
                    if (data_a_valid) begin
                        x_reg     <= data_a;
                        state_reg <= NORM;
                        busy      <= 1'b1;
                    end
                end
                NORM: begin
                    zero_reg  <= (x_reg == 32'd0);
                    e_reg     <= 5'd31 - lzc;
                    m_reg     <= norm_m;
                    cnt_reg   <= 4'd0;
                    state_reg <= FRAC;
                end
                FRAC: begin
                    // Squaring doubles the log; an overflow past 2 yields a 1 bit.
                    m_reg    <= sq[63] ? sq[63:32] : sq[62:31];
                    frac_reg <= {frac_reg[14:0], sq[63]};
                    cnt_reg  <= cnt_reg + 4'd1;
                    if (cnt_reg == 4'd15) begin
`ifdef LOG_LN_SCALE_EN
                        state_reg <= SCALE;
`else
                        state_reg <= DONE;
                        busy      <= 1'b0;
`endif
                    end
                end
                SCALE: begin
`ifdef LOG_LN_SCALE_EN
                    result_reg <= zero_reg ? 32'h8000_0000 : scale_prod[47:16];
`endif
                    state_reg  <= DONE;
                    busy       <= 1'b0;
                end
                DONE: begin
                    data_log        <= done_word;
                    data_log_valide <= 1'b1;
                    if (data_a_valid) begin
                        x_reg     <= data_a;
                        state_reg <= NORM;
                        busy      <= 1'b1;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_log2_core.sv
// Directed bench for log2_core; build with +define+LOG_LN_SCALE_EN to check the ln variant.
module tb_log2_core;

`ifdef LOG_LN_SCALE_EN
    localparam int L = 19;
    localparam logic [31:0] EXP_ONE = 32'h0000_0000;
    localparam logic [31:0] EXP_TWO = 32'h0000_B172;
    localparam logic [31:0] EXP_TOP = 32'h0015_7CCE;
`else
    localparam int L = 18;
    localparam logic [31:0] EXP_ONE = 32'h0000_0000;
    localparam logic [31:0] EXP_TWO = 32'h0001_0000;
    localparam logic [31:0] EXP_TOP = 32'h001F_0000;
`endif

    logic        hclk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] data_a = 32'd0;
    logic        data_a_valid = 1'b0;
    logic [31:0] data_log;
    logic        data_log_valide;
    logic        busy;
    logic        overrun;

    int tests = 0;
    int failed = 0;

    log2_core dut (
        .hclk(hclk),
        .rst(rst),
        .data_a(data_a),
        .data_a_valid(data_a_valid),
        .data_log(data_log),
        .data_log_valide(data_log_valide),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Pulses the strobe so that the next rising edge accepts it; returns #1 after that edge.
    task automatic start(input logic [31:0] d);
        @(negedge hclk);
        data_a       = d;
        data_a_valid = 1'b1;
        @(posedge hclk);
        #1;
        data_a_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until the result strobe, bounded.
    task automatic wait_valid(input int from, output int cyc);
        cyc = -1;
        for (int k = from + 1; k <= 45; k++) begin
            @(posedge hclk);
            #1;
            if (data_log_valide) begin
                cyc = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] d, input logic [31:0] exp);
        int cyc;
        start(d);
        wait_valid(0, cyc);
        chk({tag, " latency"}, 32'(cyc), 32'(L));
        chk({tag, " data"}, data_log, exp);
        @(posedge hclk);
        #1;
        chk({tag, " strobe width"}, {31'b0, data_log_valide}, 32'd0);
        chk({tag, " held"}, data_log, exp);
    endtask

    int cyc;
    int extra;
    logic [31:0] got;
    logic near;

    initial begin
        #1;
        chk("reset data_log", data_log, 32'd0);
        chk("reset flags", {28'b0, data_log_valide, busy, overrun, 1'b0}, 32'd0);
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        rst = 1'b0;

        run_op("x=1", 32'd1, EXP_ONE);
        run_op("x=2", 32'd2, EXP_TWO);
        run_op("x=2^31", 32'h8000_0000, EXP_TOP);
        run_op("x=0", 32'd0, 32'h8000_0000);

`ifndef LOG_LN_SCALE_EN
        start(32'd3);
        wait_valid(0, cyc);
        chk("x=3 latency", 32'(cyc), 32'(L));
        got  = data_log;
        near = (got >= 32'h0001_95BF) && (got <= 32'h0001_95C1);
        chk("x=3 within 1 LSB of 0001_95C0", {31'b0, near}, 32'd1);
`endif

        // Busy during flight, overrun on a strobe sampled mid-operation.
        start(32'd2);
        chk("busy after accept", {31'b0, busy}, 32'd1);
        repeat (4) begin
            @(posedge hclk);
            #1;
        end
        data_a       = 32'd1;
        data_a_valid = 1'b1;
        @(posedge hclk);
        #1;
        data_a_valid = 1'b0;
        chk("overrun pulse", {31'b0, overrun}, 32'd1);
        @(posedge hclk);
        #1;
        chk("overrun one cycle", {31'b0, overrun}, 32'd0);
        wait_valid(6, cyc);
        chk("overrun op latency", 32'(cyc), 32'(L));
        chk("overrun op keeps first operand", data_log, EXP_TWO);
        extra = 0;
        repeat (25) begin
            @(posedge hclk);
            #1;
            if (data_log_valide) extra++;
        end
        chk("dropped request gives no result", 32'(extra), 32'd0);

        // New request accepted in DONE, on the edge that raises the strobe.
        start(32'd1);
        for (int k = 1; k < L; k++) begin
            @(posedge hclk);
            #1;
        end
        data_a       = 32'd2;
        data_a_valid = 1'b1;
        @(posedge hclk);
        #1;
        data_a_valid = 1'b0;
        chk("b2b first strobe", {31'b0, data_log_valide}, 32'd1);
        chk("b2b first data", data_log, EXP_ONE);
        wait_valid(0, cyc);
        chk("b2b DONE accept latency", 32'(cyc), 32'(L));
        chk("b2b DONE accept data", data_log, EXP_TWO);

        // New request presented during the strobe cycle itself.
        start(32'h8000_0000);
        wait_valid(0, cyc);
        data_a       = 32'd1;
        data_a_valid = 1'b1;
        @(posedge hclk);
        #1;
        data_a_valid = 1'b0;
        wait_valid(0, cyc);
        chk("strobe-cycle request latency", 32'(cyc), 32'(L));
        chk("strobe-cycle request data", data_log, EXP_ONE);

        // Reset pulse during FRAC aborts the computation.
        start(32'd2);
        repeat (5) begin
            @(posedge hclk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("mid-op reset data_log", data_log, 32'd0);
        chk("mid-op reset flags", {29'b0, data_log_valide, busy, overrun}, 32'd0);
        @(negedge hclk);
        rst = 1'b0;
        extra = 0;
        repeat (25) begin
            @(posedge hclk);
            #1;
            if (data_log_valide) extra++;
        end
        chk("aborted op gives no result", 32'(extra), 32'd0);
        run_op("after reset x=2", 32'd2, EXP_TWO);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
